// File: rtl/kf_pkg.sv
// Shared Kalman-filter datapath definitions: default word/bank geometry and word type.
package kf_pkg;

  localparam int KF_W     = 24;
  localparam int KF_NR    = 32;
  localparam int KF_ADDRW = 5;

  typedef logic [KF_W-1:0] word_t;

endpackage

// File: rtl/acc_reg.sv
// W-bit enable-load register with asynchronous active-low clear; used for RQ and RD.
module acc_reg
  import kf_pkg::*;
#(
  parameter int W = KF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] value_d;
  logic [W-1:0] value_q;

  always_comb begin
    value_d = value_q;
    if (we) value_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign q = value_q;

endmodule

// File: rtl/mem_reg.sv
// Kalman-filter memory-register block: NR-entry dual-read/single-write data bank with
// optional write-through forwarding, plus the RQ and RD accumulator registers.
module mem_reg
  import kf_pkg::*;
#(
  parameter int W       = KF_W,
  parameter int NR      = KF_NR,
  parameter int ADDRW   = KF_ADDRW,
  parameter bit FORWARD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [ADDRW-1:0] dira,
  input  logic [ADDRW-1:0] dirb,
  input  logic [W-1:0]     data,
  output logic [W-1:0]     A,
  output logic [W-1:0]     B,
  input  logic             rq_we,
  input  logic [W-1:0]     rq_d,
  output logic [W-1:0]     RQ,
  input  logic             rd_we,
  input  logic [W-1:0]     rd_d,
  output logic [W-1:0]     RD
);

  function automatic logic in_range(input logic [ADDRW-1:0] addr);
    return (32'(addr) < NR);
  endfunction

  logic [W-1:0] mem_d [NR];
  logic [W-1:0] mem_q [NR];
  logic         wr_en;
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;

  // A write only takes effect (and only forwards) when it lands in the bank and reset is released.
  assign wr_en = write && rst_n && in_range(dira);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[dira] = data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_range(dira)) rd_a = mem_q[dira];
    if (in_range(dirb)) rd_b = mem_q[dirb];
    if (FORWARD && wr_en) begin
      rd_a = data;
      if (dirb == dira) rd_b = data;
    end
  end

  assign A = rd_a;
  assign B = rd_b;

  acc_reg #(.W(W)) u_rq (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rq_we),
    .d     (rq_d),
    .q     (RQ)
  );

  acc_reg #(.W(W)) u_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rd_we),
    .d     (rd_d),
    .q     (RD)
  );

endmodule

// File: tb/tb_mem_reg.sv
// Self-checking bench for mem_reg: directed scenarios plus randomized traffic against an
// array-based reference model of the bank and the two accumulator registers.
module tb_mem_reg;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [4:0]  dira;
  logic [4:0]  dirb;
  logic [23:0] data;
  logic [23:0] A;
  logic [23:0] B;
  logic        rq_we;
  logic [23:0] rq_d;
  logic [23:0] RQ;
  logic        rd_we;
  logic [23:0] rd_d;
  logic [23:0] RD;

  int checks = 0;
  int errors = 0;

  logic [23:0] mdl [32];
  logic [23:0] mdl_rq;
  logic [23:0] mdl_rd;

  mem_reg #(.W(24), .NR(32), .ADDRW(5), .FORWARD(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .write (write),
    .dira  (dira),
    .dirb  (dirb),
    .data  (data),
    .A     (A),
    .B     (B),
    .rq_we (rq_we),
    .rq_d  (rq_d),
    .RQ    (RQ),
    .rd_we (rd_we),
    .rd_d  (rd_d),
    .RD    (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] patt(input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {8'hA5, lo, 8'h5A};
  endfunction

  // One full cycle: apply inputs, check combinational reads, clock, check registered state.
  task automatic drive_cycle(input logic w, input logic [4:0] a, input logic [4:0] b,
                             input logic [23:0] dat, input logic qwe, input logic [23:0] qd,
                             input logic dwe, input logic [23:0] dd);
    write = w; dira = a; dirb = b; data = dat;
    rq_we = qwe; rq_d = qd; rd_we = dwe; rd_d = dd;
    #1;
    chk("A_pre", A, w ? dat : mdl[a]);
    chk("B_pre", B, (w && (b == a)) ? dat : mdl[b]);
    @(posedge clk);
    if (w)   mdl[a] = dat;
    if (qwe) mdl_rq = qd;
    if (dwe) mdl_rd = dd;
    #1;
    write = 1'b0; rq_we = 1'b0; rd_we = 1'b0;
    #1;
    chk("RQ", RQ, mdl_rq);
    chk("RD", RD, mdl_rd);
    chk("A_post", A, mdl[a]);
    chk("B_post", B, mdl[b]);
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; dira = '0; dirb = '0; data = '0;
    rq_we = 1'b0; rq_d = '0; rd_we = 1'b0; rd_d = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl_rq = '0; mdl_rd = '0;

    #3;
    chk("rst_A", A, 24'h0);
    chk("rst_B", B, 24'h0);
    chk("rst_RQ", RQ, 24'h0);
    chk("rst_RD", RD, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the bank and read back crossed.
    for (int i = 0; i < 32; i++)
      drive_cycle(1'b1, 5'(i), 5'(31 - i), patt(i), 1'b0, 24'h0, 1'b0, 24'h0);
    for (int i = 0; i < 32; i++) begin
      dira = 5'(i); dirb = 5'(31 - i);
      #1;
      chk("fill_A", A, patt(i));
      chk("fill_B", B, patt(31 - i));
    end

    // Forwarding on A with a different B address.
    drive_cycle(1'b1, 5'd3, 5'd2, 24'hDEADBE, 1'b0, 24'h0, 1'b0, 24'h0);
    dira = 5'd3; dirb = 5'd2; #1;
    chk("fwd3_A", A, 24'hDEADBE);
    chk("fwd3_B", B, patt(2));

    // Accumulator loads and hold.
    drive_cycle(1'b0, 5'd0, 5'd1, 24'h0, 1'b1, 24'h001111, 1'b1, 24'h223333);
    chk("rq1", RQ, 24'h001111);
    chk("rd1", RD, 24'h223333);
    drive_cycle(1'b0, 5'd0, 5'd1, 24'h0, 1'b1, 24'hAABBCC, 1'b1, 24'hCCDDEE);
    chk("rq2", RQ, 24'hAABBCC);
    chk("rd2", RD, 24'hCCDDEE);
    drive_cycle(1'b0, 5'd0, 5'd1, 24'h0, 1'b0, 24'h999999, 1'b0, 24'h888888);
    chk("rq_hold", RQ, 24'hAABBCC);
    chk("rd_hold", RD, 24'hCCDDEE);

    // Same-address forwarding to both ports.
    write = 1'b1; dira = 5'd7; dirb = 5'd7; data = 24'h123456; #1;
    chk("fwd7_A", A, 24'h123456);
    chk("fwd7_B", B, 24'h123456);
    drive_cycle(1'b1, 5'd7, 5'd7, 24'h123456, 1'b0, 24'h0, 1'b0, 24'h0);

    // Randomized traffic, all three state elements independent.
    for (int n = 0; n < 300; n++)
      drive_cycle(1'($urandom), 5'($urandom), 5'($urandom), 24'($urandom),
                  1'($urandom), 24'($urandom), 1'($urandom), 24'($urandom));

    // Reset asserted mid-cycle with a write and loads pending.
    #2;
    rst_n = 1'b0; write = 1'b1; dira = 5'd9; dirb = 5'd9; data = 24'h777777;
    rq_we = 1'b1; rq_d = 24'h555555; rd_we = 1'b1; rd_d = 24'h444444;
    #1;
    chk("mrst_A", A, 24'h0);
    chk("mrst_B", B, 24'h0);
    chk("mrst_RQ", RQ, 24'h0);
    chk("mrst_RD", RD, 24'h0);
    @(posedge clk); #1;
    chk("mrst_edge_RQ", RQ, 24'h0);
    write = 1'b0; rq_we = 1'b0; rd_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl_rq = '0; mdl_rd = '0;
    for (int i = 0; i < 32; i++) begin
      dira = 5'(i); dirb = 5'(31 - i);
      #0.1;
      chk("clr_A", A, mdl[i]);
      chk("clr_B", B, mdl[31 - i]);
    end
    @(posedge clk); #1;

    // Post-reset sanity with fresh random traffic.
    for (int n = 0; n < 50; n++)
      drive_cycle(1'($urandom), 5'($urandom), 5'($urandom), 24'($urandom),
                  1'($urandom), 24'($urandom), 1'($urandom), 24'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
